// File: rtl/pea_core_param.sv
// Polynomial Evaluation Accelerator core: coefficient slots, Horner evaluation
// with one MAC per cycle, FWFT FIFO handshakes on all four token streams.
module pea_core_param #(
    parameter int unsigned word_size   = 16,
    parameter int unsigned buffer_size = 1024,
    parameter int unsigned NUM_SLOTS   = 8,
    parameter int unsigned MAX_DEGREE  = 10,
    parameter int unsigned B_W         = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [word_size-1:0]           command_in,
    input  logic [$clog2(buffer_size):0]   command_pop,
    output logic                           command_rd_en,
    input  logic [word_size-1:0]           data_in,
    input  logic [$clog2(buffer_size):0]   data_pop,
    output logic                           data_rd_en,
    input  logic [$clog2(buffer_size):0]   result_free_space,
    output logic                           result_wr_en,
    output logic [2*word_size-1:0]         result_out,
    input  logic [$clog2(buffer_size):0]   status_free_space,
    output logic                           status_wr_en,
    output logic [2*word_size-1:0]         status_out,
    output logic                           busy
);

    localparam int unsigned A_W   = $clog2(NUM_SLOTS);
    localparam int unsigned PW    = $clog2(buffer_size) + 1;
    localparam int unsigned RW    = 2 * word_size;
    localparam int unsigned D_W   = $clog2(MAX_DEGREE + 1);
    localparam int unsigned PAD_W = RW - 16 - A_W - B_W;

    localparam logic [7:0] OP_STP = 8'h01;
    localparam logic [7:0] OP_EVP = 8'h02;
    localparam logic [7:0] OP_EVB = 8'h03;
    localparam logic [7:0] OP_RST = 8'h04;

    localparam logic [7:0] ST_OK      = 8'd0;
    localparam logic [7:0] ST_BAD_OP  = 8'd1;
    localparam logic [7:0] ST_UNSET   = 8'd2;
    localparam logic [7:0] ST_BAD_DEG = 8'd3;
    localparam logic [7:0] ST_EVB_0   = 8'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_STP_LOAD,
        S_EV_FETCH,
        S_EV_CALC,
        S_EV_WRITE,
        S_STATUS
    } state_t;

    state_t                        state;
    logic [7:0]                    cmd_op;
    logic [A_W-1:0]                cmd_a;
    logic [B_W-1:0]                cmd_b;
    logic [D_W-1:0]                cnt;
    logic [B_W-1:0]                ev_cnt;
    logic signed [word_size-1:0]   x;
    logic signed [RW-1:0]          acc;
    logic [NUM_SLOTS-1:0]          deg_valid;
    logic [D_W-1:0]                deg [NUM_SLOTS];
    logic signed [word_size-1:0]   coef [NUM_SLOTS][MAX_DEGREE+1];

    logic [D_W-1:0]                slot_deg_c;
    logic signed [word_size-1:0]   coef_n_c;
    logic signed [word_size-1:0]   coef_k_c;
    logic signed [RW-1:0]          mac_c;
    logic                          bad_op_c;
    logic                          unset_c;
    logic                          bad_deg_c;
    logic                          evb_zero_c;

    function automatic logic [RW-1:0] status_word(input logic [7:0] code, input logic [7:0] op,
                                                  input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        status_word = {code, op, PAD_W'(0), a, b};
    endfunction

    // Horner step operands and decode-time error checks
    always_comb begin
        slot_deg_c = deg[cmd_a];
        coef_n_c   = coef[cmd_a][slot_deg_c];
        coef_k_c   = coef[cmd_a][cnt];
        mac_c      = acc * RW'(x) + RW'(coef_k_c);
        bad_op_c   = !(cmd_op == OP_STP || cmd_op == OP_EVP || cmd_op == OP_EVB || cmd_op == OP_RST);
        unset_c    = (cmd_op == OP_EVP || cmd_op == OP_EVB) && !deg_valid[cmd_a];
        bad_deg_c  = (cmd_op == OP_STP) && (cmd_b > B_W'(MAX_DEGREE));
        evb_zero_c = (cmd_op == OP_EVB) && (cmd_b == '0);
    end

    // Coefficient storage survives reset; only the degree valid bits are cleared
    always_ff @(posedge clk) begin
        if (state == S_STP_LOAD) begin
            coef[cmd_a][cnt] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            command_rd_en <= 1'b0;
            data_rd_en    <= 1'b0;
            result_wr_en  <= 1'b0;
            status_wr_en  <= 1'b0;
            result_out    <= '0;
            status_out    <= '0;
            busy          <= 1'b0;
            cmd_op        <= '0;
            cmd_a         <= '0;
            cmd_b         <= '0;
            cnt           <= '0;
            ev_cnt        <= '0;
            x             <= '0;
            acc           <= '0;
            deg_valid     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                deg[i] <= '0;
            end
        end else begin
            command_rd_en <= 1'b0;
            data_rd_en    <= 1'b0;
            result_wr_en  <= 1'b0;
            status_wr_en  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (command_pop != '0 && status_free_space != '0) begin
                        command_rd_en <= 1'b1;
                        cmd_op        <= command_in[word_size-1 -: 8];
                        cmd_a         <= command_in[A_W+B_W-1:B_W];
                        cmd_b         <= command_in[B_W-1:0];
                        busy          <= 1'b1;
                        state         <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (bad_op_c || unset_c || bad_deg_c || evb_zero_c) begin
                        status_wr_en <= 1'b1;
                        status_out   <= status_word(bad_op_c  ? ST_BAD_OP  :
                                                    unset_c   ? ST_UNSET   :
                                                    bad_deg_c ? ST_BAD_DEG : ST_EVB_0,
                                                    cmd_op, cmd_a, cmd_b);
                        state        <= S_STATUS;
                    end else begin
                        case (cmd_op)
                            OP_STP: begin
                                if (data_pop >= PW'(cmd_b) + PW'(1)) begin
                                    data_rd_en <= 1'b1;
                                    cnt        <= '0;
                                    state      <= S_STP_LOAD;
                                end
                            end
                            OP_EVP: begin
                                if (data_pop != '0 && result_free_space != '0) begin
                                    data_rd_en <= 1'b1;
                                    ev_cnt     <= '0;
                                    state      <= S_EV_FETCH;
                                end
                            end
                            OP_EVB: begin
                                // all b arguments and all b result slots must be available up front
                                if (data_pop >= PW'(cmd_b) && result_free_space >= PW'(cmd_b)) begin
                                    data_rd_en <= 1'b1;
                                    ev_cnt     <= '0;
                                    state      <= S_EV_FETCH;
                                end
                            end
                            default: begin
                                deg_valid    <= '0;
                                status_wr_en <= 1'b1;
                                status_out   <= status_word(ST_OK, cmd_op, cmd_a, cmd_b);
                                state        <= S_STATUS;
                            end
                        endcase
                    end
                end
                S_STP_LOAD: begin
                    if (cnt == D_W'(cmd_b)) begin
                        deg[cmd_a]       <= D_W'(cmd_b);
                        deg_valid[cmd_a] <= 1'b1;
                        status_wr_en     <= 1'b1;
                        status_out       <= status_word(ST_OK, cmd_op, cmd_a, cmd_b);
                        state            <= S_STATUS;
                    end else begin
                        cnt        <= cnt + D_W'(1);
                        data_rd_en <= 1'b1;
                    end
                end
                S_EV_FETCH: begin
                    x   <= data_in;
                    acc <= RW'(coef_n_c);
                    if (slot_deg_c == '0) begin
                        result_out   <= RW'(coef_n_c);
                        result_wr_en <= 1'b1;
                        state        <= S_EV_WRITE;
                    end else begin
                        cnt   <= slot_deg_c - D_W'(1);
                        state <= S_EV_CALC;
                    end
                end
                S_EV_CALC: begin
                    acc <= mac_c;
                    if (cnt == '0) begin
                        result_out   <= mac_c;
                        result_wr_en <= 1'b1;
                        state        <= S_EV_WRITE;
                    end else begin
                        cnt <= cnt - D_W'(1);
                    end
                end
                S_EV_WRITE: begin
                    if (cmd_op == OP_EVB && ev_cnt != cmd_b - B_W'(1)) begin
                        ev_cnt     <= ev_cnt + B_W'(1);
                        data_rd_en <= 1'b1;
                        state      <= S_EV_FETCH;
                    end else begin
                        status_wr_en <= 1'b1;
                        status_out   <= status_word(ST_OK, cmd_op, cmd_a, cmd_b);
                        state        <= S_STATUS;
                    end
                end
                S_STATUS: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pea_core_param.sv
// Directed bench for pea_core_param: FIFO models around the core, expected
// results/status pushed to scoreboard queues and checked as tokens are written.
module tb_pea_core_param;

    localparam int unsigned PW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   command_in = '0;
    logic [PW-1:0] command_pop = '0;
    logic          command_rd_en;
    logic [15:0]   data_in = '0;
    logic [PW-1:0] data_pop = '0;
    logic          data_rd_en;
    logic [PW-1:0] result_free_space = 11'd16;
    logic          result_wr_en;
    logic [31:0]   result_out;
    logic [PW-1:0] status_free_space = 11'd16;
    logic          status_wr_en;
    logic [31:0]   status_out;
    logic          busy;

    pea_core_param dut (
        .clk(clk), .rst_n(rst_n),
        .command_in(command_in), .command_pop(command_pop), .command_rd_en(command_rd_en),
        .data_in(data_in), .data_pop(data_pop), .data_rd_en(data_rd_en),
        .result_free_space(result_free_space), .result_wr_en(result_wr_en), .result_out(result_out),
        .status_free_space(status_free_space), .status_wr_en(status_wr_en), .status_out(status_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int d_pops = 0;
    int n_res = 0;
    logic [15:0] cq[$];
    logic [15:0] dq[$];
    logic [31:0] res_exp[$];
    logic [31:0] st_exp[$];
    logic c_take, d_take;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stw(input logic [7:0] code, input logic [7:0] op,
                                        input logic [2:0] a, input logic [4:0] b);
        stw = {code, op, 8'h00, a, b};
    endfunction

    // FWFT FIFO models: pop on edges where the core held rd_en, then refresh heads
    always @(posedge clk) begin
        c_take = command_rd_en;
        d_take = data_rd_en;
        #1;
        if (c_take && cq.size() > 0) void'(cq.pop_front());
        if (d_take && dq.size() > 0) begin
            void'(dq.pop_front());
            d_pops++;
        end
        command_in  = (cq.size() > 0) ? cq[0] : 16'h0;
        command_pop = PW'(cq.size());
        data_in     = (dq.size() > 0) ? dq[0] : 16'h0;
        data_pop    = PW'(dq.size());
    end

    // Output monitor: protocol rules and scoreboard comparison
    always @(negedge clk) begin
        if (rst_n) begin
            if (command_rd_en) chk("cmd_rd_nonempty", 32'(cq.size() != 0), 32'd1);
            if (data_rd_en)    chk("data_rd_nonempty", 32'(dq.size() != 0), 32'd1);
            if (result_wr_en) begin
                n_res++;
                chk("res_space", 32'(result_free_space != '0), 32'd1);
                if (res_exp.size() == 0) begin
                    total++; bad++;
                    $error("FAIL result_extra got=%h exp=none", result_out);
                end else begin
                    chk("result", result_out, res_exp.pop_front());
                end
            end
            if (status_wr_en) begin
                chk("st_space", 32'(status_free_space != '0), 32'd1);
                if (st_exp.size() == 0) begin
                    total++; bad++;
                    $error("FAIL status_extra got=%h exp=none", status_out);
                end else begin
                    chk("status", status_out, st_exp.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] op, input logic [2:0] a, input logic [4:0] b);
        cq.push_back({op, a, b});
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while ((cq.size() != 0 || res_exp.size() != 0 || st_exp.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 400), 32'd1);
    endtask

    initial begin
        int base;
        int nr;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {27'd0, command_rd_en, data_rd_en, result_wr_en, status_wr_en, busy}, 32'd0);
        chk("rst_result_out", result_out, 32'd0);
        chk("rst_status_out", status_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // STP slot2 = {1,2,3}
        base = d_pops;
        dq.push_back(16'd1); dq.push_back(16'd2); dq.push_back(16'd3);
        st_exp.push_back(stw(8'd0, 8'h01, 3'd2, 5'd2));
        send(8'h01, 3'd2, 5'd2);
        wait_done("stp_done");
        chk("stp_pops", 32'(d_pops - base), 32'd3);

        // EVP slot2 at x=2
        dq.push_back(16'd2);
        res_exp.push_back(32'd17);
        st_exp.push_back(stw(8'd0, 8'h02, 3'd2, 5'd0));
        send(8'h02, 3'd2, 5'd0);
        wait_done("evp_done");

        // EVB slot2 at -1,0,1
        dq.push_back(16'hFFFF); dq.push_back(16'd0); dq.push_back(16'd1);
        res_exp.push_back(32'd2); res_exp.push_back(32'd1); res_exp.push_back(32'd6);
        st_exp.push_back(stw(8'd0, 8'h03, 3'd2, 5'd3));
        send(8'h03, 3'd2, 5'd3);
        wait_done("evb_done");

        // EVP on unset slot consumes no data
        dq.push_back(16'd7);
        @(negedge clk); @(negedge clk);
        base = d_pops;
        st_exp.push_back(stw(8'd2, 8'h02, 3'd5, 5'd0));
        send(8'h02, 3'd5, 5'd0);
        wait_done("unset_done");
        chk("unset_no_pop", 32'(d_pops - base), 32'd0);
        chk("unset_datapop", 32'(data_pop), 32'd1);
        dq.delete();

        // error codes
        st_exp.push_back(stw(8'd3, 8'h01, 3'd1, 5'd12));
        send(8'h01, 3'd1, 5'd12);
        wait_done("deg_err_done");
        st_exp.push_back(stw(8'd1, 8'h7F, 3'd1, 5'd3));
        send(8'h7F, 3'd1, 5'd3);
        wait_done("badop_done");
        st_exp.push_back(stw(8'd4, 8'h03, 3'd2, 5'd0));
        send(8'h03, 3'd2, 5'd0);
        wait_done("evb0_done");

        // EVB waits until all three arguments are present
        base = d_pops;
        nr = n_res;
        dq.push_back(16'd3);
        res_exp.push_back(32'd34); res_exp.push_back(32'd9); res_exp.push_back(32'd1);
        st_exp.push_back(stw(8'd0, 8'h03, 3'd2, 5'd3));
        send(8'h03, 3'd2, 5'd3);
        repeat (12) @(negedge clk);
        chk("evb_hold_busy", 32'(busy), 32'd1);
        chk("evb_hold_pops", 32'(d_pops - base), 32'd0);
        chk("evb_hold_res", 32'(n_res - nr), 32'd0);
        dq.push_back(16'hFFFE); dq.push_back(16'd0);
        wait_done("evb_fill_done");
        chk("evb_fill_pops", 32'(d_pops - base), 32'd3);

        // EVP holds with no result space
        result_free_space = '0;
        base = d_pops;
        nr = n_res;
        dq.push_back(16'd1);
        res_exp.push_back(32'd6);
        st_exp.push_back(stw(8'd0, 8'h02, 3'd2, 5'd0));
        send(8'h02, 3'd2, 5'd0);
        repeat (12) @(negedge clk);
        chk("nospace_busy", 32'(busy), 32'd1);
        chk("nospace_pops", 32'(d_pops - base), 32'd0);
        chk("nospace_res", 32'(n_res - nr), 32'd0);
        result_free_space = 11'd16;
        wait_done("nospace_done");

        // wrap modulo 2^32: slot4 = {7FFF,7FFF,7FFF}, x = 7FFF
        dq.push_back(16'h7FFF); dq.push_back(16'h7FFF); dq.push_back(16'h7FFF);
        st_exp.push_back(stw(8'd0, 8'h01, 3'd4, 5'd2));
        send(8'h01, 3'd4, 5'd2);
        wait_done("wrap_stp_done");
        dq.push_back(16'h7FFF);
        res_exp.push_back(32'h8000FFFF);
        st_exp.push_back(stw(8'd0, 8'h02, 3'd4, 5'd0));
        send(8'h02, 3'd4, 5'd0);
        wait_done("wrap_evp_done");

        // degree 0 with negative constant
        dq.push_back(16'hFFFB);
        st_exp.push_back(stw(8'd0, 8'h01, 3'd6, 5'd0));
        send(8'h01, 3'd6, 5'd0);
        wait_done("deg0_stp_done");
        dq.push_back(16'd9);
        res_exp.push_back(32'hFFFFFFFB);
        st_exp.push_back(stw(8'd0, 8'h02, 3'd6, 5'd0));
        send(8'h02, 3'd6, 5'd0);
        wait_done("deg0_evp_done");

        // RST opcode invalidates slots
        st_exp.push_back(stw(8'd0, 8'h04, 3'd0, 5'd0));
        send(8'h04, 3'd0, 5'd0);
        wait_done("rstop_done");
        st_exp.push_back(stw(8'd2, 8'h02, 3'd4, 5'd0));
        send(8'h02, 3'd4, 5'd0);
        wait_done("rstop_unset_done");

        // async reset during STP_LOAD after the second coefficient
        base = d_pops;
        for (int i = 0; i < 5; i++) dq.push_back(16'(10 + i));
        send(8'h01, 3'd3, 5'd4);
        nr = 0;
        while (d_pops - base < 2 && nr < 200) begin
            @(negedge clk);
            nr++;
        end
        chk("mid_load_reached", 32'(nr < 200), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {27'd0, command_rd_en, data_rd_en, result_wr_en, status_wr_en, busy}, 32'd0);
        chk("midrst_result_out", result_out, 32'd0);
        chk("midrst_status_out", status_out, 32'd0);
        @(negedge clk);
        dq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle", 32'(busy), 32'd0);
        st_exp.push_back(stw(8'd2, 8'h02, 3'd3, 5'd0));
        send(8'h02, 3'd3, 5'd0);
        wait_done("midrst_unset_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
